// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader.
// Debouncing is compiled in only when OPLOAD_DEBOUNCE_EN is defined.
package operand_loader_pkg;

  localparam int unsigned DEFAULT_DATA_W       = 4;
  localparam int unsigned DEFAULT_NUM_OPS      = 4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYC = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StNotify
  } state_e;

  // Counter must hold DEBOUNCE_CYC-1; a 1-cycle debounce still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

  localparam int unsigned DEB_CNT_W = cnt_width(DEFAULT_DEBOUNCE_CYC);

endpackage

// File: rtl/operand_loader_if.sv
// Update channel from the operand loader to the compute block: operands plus
// a valid/ready event carrying the mask of operands just written.
interface operand_loader_if
  import operand_loader_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned NUM_OPS = DEFAULT_NUM_OPS
) ();

  logic [NUM_OPS*DATA_W-1:0] ops_out;
  logic                      upd_valid;
  logic [NUM_OPS-1:0]        upd_mask;
  logic                      upd_ready;

  modport master (
    output ops_out,
    output upd_valid,
    output upd_mask,
    input  upd_ready
  );

  modport slave (
    input  ops_out,
    input  upd_valid,
    input  upd_mask,
    output upd_ready
  );

endinterface

// File: rtl/strobe_debouncer.sv
// One load strobe: 2-flop synchroniser, optional debounce counter
// (OPLOAD_DEBOUNCE_EN) and a one-cycle pulse on each accepted rising edge.
module strobe_debouncer
  import operand_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int unsigned CNT_W        = DEB_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic rise_o
);

  logic sync1_q, sync2_q;
  logic level;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= strobe_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef OPLOAD_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYC - 1);

  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter measures how long the synced level has disagreed with the accepted one.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = deb_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{DEBOUNCE_CYC, CNT_W};
  assign level      = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise_o = level & ~prev_q;

endmodule

// File: rtl/operand_loader.sv
// Operand loader: synchronised switch nibble written into operand registers on
// debounced strobe presses (debounce enabled by OPLOAD_DEBOUNCE_EN), one
// valid/ready event per press.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned NUM_OPS      = DEFAULT_NUM_OPS,
  parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  data_in_i,
  input  logic [NUM_OPS-1:0] load_req_i,
  output logic               busy_o,
  operand_loader_if.master   upd
);

  logic [DATA_W-1:0]         data_sync1_q, data_sync2_q;
  logic [NUM_OPS-1:0]        rise;
  state_e                    state_q, state_d;
  logic [NUM_OPS-1:0]        pending_q, pending_d;
  logic [NUM_OPS-1:0]        mask_q, mask_d;
  logic [NUM_OPS*DATA_W-1:0] ops_q, ops_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync1_q <= '0;
      data_sync2_q <= '0;
    end else begin
      data_sync1_q <= data_in_i;
      data_sync2_q <= data_sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_strobe
    strobe_debouncer #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (cnt_width(DEBOUNCE_CYC))
    ) u_debouncer (
      .clk      (clk),
      .rst_n    (rst_n),
      .strobe_i (load_req_i[i]),
      .rise_o   (rise[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | rise;
    mask_d    = mask_q;
    ops_d     = ops_q;
    unique case (state_q)
      StIdle: begin
        if (pending_q != '0) state_d = StCapture;
      end
      StCapture: begin
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
          if (pending_q[i]) ops_d[i*DATA_W +: DATA_W] = data_sync2_q;
        end
        mask_d    = pending_q;
        // Edges landing in this same cycle survive for the next event.
        pending_d = rise;
        state_d   = StNotify;
      end
      StNotify: begin
        if (upd.upd_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      mask_q    <= '0;
      ops_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ops_q     <= ops_d;
    end
  end

  assign upd.ops_out   = ops_q;
  assign upd.upd_valid = (state_q == StNotify);
  assign upd.upd_mask  = mask_q;
  assign busy_o        = (state_q != StIdle) || (pending_q != '0);

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: window-based behavioural model
// compared every cycle, plus directed literal checks; follows OPLOAD_DEBOUNCE_EN.
module tb_operand_loader;

  localparam int unsigned DW = 4;
  localparam int unsigned NO = 4;
  localparam int unsigned DC = 8;
`ifdef OPLOAD_DEBOUNCE_EN
  localparam bit DebEn = 1'b1;
`else
  localparam bit DebEn = 1'b0;
`endif
  localparam int Lat = DebEn ? 4 + DC : 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [NO-1:0] load_req = '0;
  logic          busy;

  operand_loader_if #(.DATA_W(DW), .NUM_OPS(NO)) upd_if ();

  operand_loader #(
    .DATA_W       (DW),
    .NUM_OPS      (NO),
    .DEBOUNCE_CYC (DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in_i  (data_in),
    .load_req_i (load_req),
    .busy_o     (busy),
    .upd        (upd_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Synced level at edge e is the raw level sampled at e-1. A debounced level
  // flips once the last DC synced samples all disagree with it. A rise of the
  // debounced level is visible as a press one edge later.
  logic [NO-1:0] s_req;
  logic [DW-1:0] s_data;
  logic          s_rdy;
  logic          s_live;

  logic [NO-1:0] m_r1, m_deb1, m_deb2, m_pend, m_mask;
  logic [DW-1:0] m_d1, m_dsync;
  logic [NO-1:0] m_hist [DC];
  logic [DW-1:0] m_ops [NO];
  int            m_phase;  // 0 idle, 1 capture, 2 announcing

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_live <= 1'b0;
    else begin
      s_live <= 1'b1;
      s_req  <= load_req;
      s_data <= data_in;
      s_rdy  <= upd_if.upd_ready;
    end
  end

  task automatic model_reset();
    m_r1 = '0; m_deb1 = '0; m_deb2 = '0; m_pend = '0; m_mask = '0;
    m_d1 = '0; m_dsync = '0; m_phase = 0;
    for (int j = 0; j < int'(DC); j++) m_hist[j] = '0;
    for (int i = 0; i < int'(NO); i++) m_ops[i] = '0;
  endtask

  task automatic model_step(input logic [NO-1:0] req, input logic [DW-1:0] data,
                            input logic rdy);
    logic [NO-1:0] new_sync, new_deb, rise;
    bit            all_diff;
    new_sync = m_r1;
    rise     = m_deb1 & ~m_deb2;
    if (DebEn) begin
      for (int b = 0; b < int'(NO); b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < int'(DC); j++) if (m_hist[j][b] == m_deb1[b]) all_diff = 1'b0;
        new_deb[b] = all_diff ? ~m_deb1[b] : m_deb1[b];
      end
    end else begin
      new_deb = new_sync;
    end
    case (m_phase)
      0: begin
        if (m_pend != '0) m_phase = 1;
        m_pend = m_pend | rise;
      end
      1: begin
        for (int i = 0; i < int'(NO); i++) if (m_pend[i]) m_ops[i] = m_dsync;
        m_mask  = m_pend;
        m_pend  = rise;
        m_phase = 2;
      end
      default: begin
        if (rdy) m_phase = 0;
        m_pend = m_pend | rise;
      end
    endcase
    m_dsync = m_d1;
    m_d1    = data;
    m_r1    = req;
    for (int j = int'(DC) - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = new_sync;
    m_deb2    = m_deb1;
    m_deb1    = new_deb;
  endtask

  always @(negedge clk) begin
    logic [NO*DW-1:0] exp_ops;
    if (!rst_n || !s_live) model_reset();
    else model_step(s_req, s_data, s_rdy);
    for (int i = 0; i < int'(NO); i++) exp_ops[i*DW +: DW] = m_ops[i];
    check("ops_cycle", 32'(upd_if.ops_out), 32'(exp_ops));
    check("valid_cycle", 32'(upd_if.upd_valid), 32'(m_phase == 2));
    check("busy_cycle", 32'(busy), 32'((m_phase != 0) || (m_pend != '0)));
    if (m_phase == 2) check("mask_cycle", 32'(upd_if.upd_mask), 32'(m_mask));
  end

  // Observation of DUT events for directed checks
  int            n_vcyc = 0;
  logic [NO-1:0] last_mask = '0;
  always @(negedge clk) begin
    if (upd_if.upd_valid) begin
      n_vcyc    <= n_vcyc + 1;
      last_mask <= upd_if.upd_mask;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [NO-1:0] m, input logic [DW-1:0] d, input int hold);
    @(negedge clk);
    data_in  = d;
    load_req = m;
    repeat (hold) @(negedge clk);
    load_req = '0;
  endtask

  // k = index of the edge (first posedge = edge 0) after which valid was seen
  task automatic wait_valid(input int max_edges, input int rel_at, output int k);
    k = -1;
    while (k < max_edges) begin
      @(posedge clk);
      #1;
      k++;
      if (k == rel_at) load_req = '0;
      if (upd_if.upd_valid) break;
    end
  endtask

  function automatic logic [DW-1:0] op(input int i);
    return upd_if.ops_out[i*DW +: DW];
  endfunction

  task automatic rand_phase(input int cycles);
    int c = 0;
    logic [NO-1:0] req;
    int hold;
    while (c < cycles) begin
      req  = ($urandom_range(0, 2) == 0) ? NO'($urandom_range(1, 15)) : '0;
      hold = $urandom_range(1, DebEn ? 14 : 4);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        data_in          = DW'($urandom);
        upd_if.upd_ready = ($urandom_range(0, 9) < 7);
        load_req         = req;
        c++;
      end
    end
    @(negedge clk);
    load_req         = '0;
    upd_if.upd_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, v0, tries;
    upd_if.upd_ready = 1'b1;
    idle(3);
    #1;
    check("reset_ops", 32'(upd_if.ops_out), 32'h0);
    check("reset_valid", 32'(upd_if.upd_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Held strobe: one event at the documented latency
    @(negedge clk);
    data_in  = 4'hA;
    load_req = 4'b0001;
    v0       = n_vcyc;
    wait_valid(40, -100, k);
    check("latency_hold", 32'(k), 32'(Lat));
    check("op0_hold", 32'(op(0)), 32'hA);
    check("mask_hold", 32'(upd_if.upd_mask), 32'b0001);
    idle(20);
    load_req = '0;
    idle(30);
    check("events_hold", 32'(n_vcyc - v0), 32'd1);

    // Short and longer pulses on strobe 1
    v0 = n_vcyc;
    press(4'b0010, 4'h7, 5);
    idle(30);
    check("events_pulse5", 32'(n_vcyc - v0), DebEn ? 32'd0 : 32'd1);
    v0 = n_vcyc;
    press(4'b0010, 4'h6, 9);
    idle(30);
    check("events_pulse9", 32'(n_vcyc - v0), 32'd1);
    check("mask_pulse9", 32'(last_mask), 32'b0010);
    check("op1_pulse9", 32'(op(1)), 32'h6);

`ifdef OPLOAD_DEBOUNCE_EN
    v0 = n_vcyc;
    press(4'b0100, 4'hC, 1);
    idle(30);
    check("events_glitch", 32'(n_vcyc - v0), 32'd0);
`else
    @(negedge clk);
    data_in  = 4'hC;
    load_req = 4'b0100;
    wait_valid(20, 0, k);
    check("latency_glitch", 32'(k), 32'd4);
    check("mask_glitch", 32'(upd_if.upd_mask), 32'b0100);
    idle(20);
`endif

    // Simultaneous strobes: single event, same nibble to both
    v0 = n_vcyc;
    press(4'b0110, 4'h5, DC + 2);
    idle(30);
    check("events_multi", 32'(n_vcyc - v0), 32'd1);
    check("mask_multi", 32'(last_mask), 32'b0110);
    check("op1_multi", 32'(op(1)), 32'h5);
    check("op2_multi", 32'(op(2)), 32'h5);
    check("op0_multi", 32'(op(0)), 32'hA);
    check("op3_multi", 32'(op(3)), 32'h0);

    // Backpressure: second press queues, data sampled at capture time
    upd_if.upd_ready = 1'b0;
    press(4'b0001, 4'h3, DC + 2);
    wait_valid(40, -100, k);
    check("bp_mask1", 32'(upd_if.upd_mask), 32'b0001);
    check("bp_op0", 32'(op(0)), 32'h3);
    press(4'b1000, 4'h3, DC + 2);
    @(negedge clk);
    data_in = 4'h9;
    idle(6);
    #1;
    check("bp_valid_held", 32'(upd_if.upd_valid), 32'd1);
    check("bp_mask_held", 32'(upd_if.upd_mask), 32'b0001);
    check("bp_op3_held", 32'(op(3)), 32'h0);
    check("bp_busy", 32'(busy), 32'd1);
    @(negedge clk);
    upd_if.upd_ready = 1'b1;
    tries = 0;
    do begin
      @(posedge clk);
      #1;
      tries++;
    end while (upd_if.upd_valid && tries < 20);
    check("bp_accept", 32'(upd_if.upd_valid), 32'd0);
    wait_valid(20, -100, k);
    check("bp_mask2", 32'(upd_if.upd_mask), 32'b1000);
    check("bp_op3", 32'(op(3)), 32'h9);
    idle(10);

    // Asynchronous reset mid-handshake with operands loaded
    upd_if.upd_ready = 1'b0;
    press(4'b0001, 4'h4, DC + 2);
    wait_valid(40, -100, k);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ops", 32'(upd_if.ops_out), 32'h0);
    check("midrst_valid", 32'(upd_if.upd_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n            = 1'b1;
    upd_if.upd_ready = 1'b1;
    idle(5);

    // Randomised traffic, with a reset in the middle
    rand_phase(1500);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    rand_phase(1500);
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
